// File: rtl/div_unit_pkg.sv
// Shared defines for the EX-stage divider: data width, op encodings, FSM states
// and the sign-fix record latched with each operation.
package div_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic is_rem;
        logic neg_q;
        logic neg_r;
    } div_fix_t;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
    import div_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic [XLEN:0] rem33;
    logic [XLEN:0] diff;

    // The partial remainder is always below dvs, so both outcomes fit in XLEN bits.
    always_comb begin
        rem33 = {rem, quo[XLEN-1]};
        diff  = rem33 - {1'b0, dvs};
        if (rem33 >= {1'b0, dvs}) begin
            rem_nxt = diff[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = rem33[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) that stalls PC..EX while busy.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish without iterating.
module div_unit
    import div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            annul,
    input  logic            ex_hold,
    output logic [XLEN-1:0] result,
    output logic            ready,
    output logic            stallreq_ex
);

    div_state_e      state, state_nxt;
    logic [5:0]      cnt;
    logic [XLEN-1:0] rem, quo, dvs;
    logic [XLEN-1:0] rem_nxt, quo_nxt;
    div_fix_t        fix;

    logic            is_signed, a_neg, b_neg;
    logic            capture, last, fast_hit;
    logic [XLEN-1:0] fin;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & dividend[XLEN-1];
    assign b_neg     = is_signed & divisor[XLEN-1];
    assign capture   = (state == DIV_IDLE) & start & ~annul;
    assign last      = (cnt == 6'd31);

`ifdef DIV_FAST_SPECIAL_EN
    logic            div_zero;
    logic [XLEN-1:0] fast_res;

    assign div_zero = (divisor == '0);
    assign fast_hit = div_zero |
                      (is_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (divisor == '1));
    // Zero divisor: q = all ones, r = dividend. Overflow: q = dividend (0x80000000), r = 0.
    assign fast_res = div_zero ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);
`else
    assign fast_hit = 1'b0;
`endif

    div_step u_step (
        .rem     (rem),
        .quo     (quo),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    assign fin = fix.is_rem ? cond_neg(rem_nxt, fix.neg_r) : cond_neg(quo_nxt, fix.neg_q);

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (capture) state_nxt = fast_hit ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (last) state_nxt = DIV_DONE;
            DIV_DONE: if (!ex_hold) state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
        if (annul) state_nxt = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            fix    <= '0;
            result <= '0;
        end else if (annul) begin
            cnt <= '0;
        end else begin
            case (state)
                DIV_IDLE: if (start) begin
                    cnt        <= '0;
                    rem        <= '0;
                    quo        <= cond_neg(dividend, a_neg);
                    dvs        <= cond_neg(divisor, b_neg);
                    fix.is_rem <= op[1];
                    // x/0 keeps the all-ones quotient unnegated.
                    fix.neg_q  <= (a_neg ^ b_neg) & (divisor != '0);
                    fix.neg_r  <= a_neg;
`ifdef DIV_FAST_SPECIAL_EN
                    if (fast_hit) result <= fast_res;
`endif
                end
                DIV_BUSY: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 6'd1;
                    if (last) result <= fin;
                end
                default: ;
            endcase
        end
    end

    assign ready       = (state == DIV_DONE);
    assign stallreq_ex = ~rst & start & ~annul & (state != DIV_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, annul/reset sequences
// and randomized operations against an arithmetic reference model.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, annul, ex_hold;
    logic [1:0]  op;
    logic [31:0] dividend, divisor, result;
    logic        ready, stallreq_ex;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .dividend    (dividend),
        .divisor     (divisor),
        .annul       (annul),
        .ex_hold     (ex_hold),
        .result      (result),
        .ready       (ready),
        .stallreq_ex (stallreq_ex)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          hold;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        case (o)
            2'b01:   return a / b;
            2'b11:   return a % b;
            2'b00:   return ovf ? a : 32'(sa / sb);
            default: return ovf ? 32'd0 : 32'(sa % sb);
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold, input string name);
        int          lat, stalls, exp_lat;
        logic [31:0] held;
        exp_lat = is_special(o, a, b) ? 1 : 33;
        @(negedge clk);
        op = o; dividend = a; divisor = b; start = 1'b1; ex_hold = 1'b0;
        #1;
        chk({name, " stall@N"}, 32'(stallreq_ex), 32'd1);
        stalls = 1;
        lat    = 0;
        while (!ready && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (!ready && stallreq_ex) stalls++;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " stall_cycles"}, stalls, exp_lat);
        chk({name, " result"}, result, exp);
        chk({name, " stall_in_done"}, 32'(stallreq_ex), 32'd0);
        held    = result;
        ex_hold = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, " hold_ready"}, 32'(ready), 32'd1);
            chk({name, " hold_result"}, result, held);
        end
        ex_hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({name, " idle_after"}, 32'(ready), 32'd0);
    endtask

    initial begin
        int          seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        rst = 1'b1; start = 1'b1; annul = 1'b0; ex_hold = 1'b0;
        op = 2'b00; dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset stallreq", 32'(stallreq_ex), 32'd0);
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset result", result, 32'd0);
        rst = 1'b0; start = 1'b0;

        tbl = '{
            '{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         0},
            '{DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          0},
            '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  0},
            '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  0},
            '{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          0},
            '{DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  0},
            '{DIV_OP_REM,  32'd5,          32'd0,          32'd5,          0},
            '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0},
            '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0},
            '{DIV_OP_DIVU, 32'd9,          32'd3,          32'd3,          5},
            '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  0},
            '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1},
            '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  0}
        };
        for (int i = 0; i < 13; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].hold, $sformatf("vec%0d", i));

        // Annul at BUSY step 10: stall drops immediately, no result ever appears.
        @(negedge clk);
        op = DIV_OP_DIVU; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        #1;
        chk("annul stallreq", 32'(stallreq_ex), 32'd0);
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready) seen++;
            @(negedge clk);
        end
        chk("annul ready_seen", seen, 0);
        run_op(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 0, "post_annul");

        // Reset at BUSY step 20.
        @(negedge clk);
        op = DIV_OP_DIVU; dividend = 32'hFFFF_FFFF; divisor = 32'd5; start = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        chk("midrst ready", 32'(ready), 32'd0);
        chk("midrst result", result, 32'd0);
        chk("midrst stallreq", 32'(stallreq_ex), 32'd0);
        run_op(DIV_OP_REMU, 32'hFFFF_FFFF, 32'd5, model(DIV_OP_REMU, 32'hFFFF_FFFF, 32'd5), 0, "post_rst");

        for (int i = 0; i < 24; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       rb = 32'd0;
                1:       begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
                2:       rb = 32'($urandom_range(1, 16));
                3:       rb = {$urandom} >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, model(ro, ra, rb), $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage. It is a stall requester: while a division is in flight it drives `stallreq_ex`, which the pipeline stall controller turns into the freeze vector for PC/IF/ID/EX. It also watches the resulting EX freeze bit so a finished result is held until the pipeline actually advances.

## Interface
- No parameters; data width is fixed at 32 (`XLEN` from the shared defines).
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: EX holds a divide instruction; level held by the frozen EX register.
- `op` in 2: `DIV_OP_DIV`=00, `DIV_OP_DIVU`=01, `DIV_OP_REM`=10, `DIV_OP_REMU`=11.
- `dividend` in 32: rs1 value.
- `divisor` in 32: rs2 value.
- `annul` in 1: flush of the EX instruction (branch/trap); aborts the operation.
- `ex_hold` in 1: stall[3] from the stall controller (EX frozen).
- `result` out 32: quotient or remainder; valid only while `ready`=1.
- `ready` out 1: result valid.
- `stallreq_ex` out 1: request to freeze PC..EX.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `start`=1 and `annul`=0: latch operands, `op`, signs and absolute values; clear the 6-bit counter; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: one restoring step per cycle.
  - rem33 = {rem[31:0], q[31]}; q <<= 1.
  - If rem33 >= {1'b0, |divisor|}: subtract and set q[0] = 1.
  - Counter increments. After the 32nd step (counter == 31), apply sign fix, register `result`, go to DONE.
- Sign fix (signed ops only):
  - Quotient is negated iff sign(a) != sign(b) and b != 0.
  - Remainder is negated iff a < 0.
  - Unsigned ops: no fix.
- RISC-V special cases must fall out of the arithmetic:
  - x/0: quotient 0xFFFFFFFF, remainder = dividend.
  - 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0.
- DONE: `ready`=1.
  - `ex_hold`=1 (frozen by a MEM stall): stay in DONE and hold `result`.
  - `ex_hold`=0: go to IDLE.
- `stallreq_ex` = `start` & ~`annul` & (state != DONE). It is combinational and is forced 0 during `rst`.
- `annul` in any state: go to IDLE next cycle, `ready`=0, counter cleared, no result.
- Back-to-back divides: after DONE→IDLE, a new `start` in IDLE captures the next instruction.

## Timing
- Reset values: state IDLE, `result`=0, `ready`=0, `stallreq_ex`=0, counter 0, internal rem/q 0.
- `start` seen in cycle N:
  - `stallreq_ex`=1 from cycle N through N+32.
  - BUSY during N+1..N+32.
  - DONE (`ready`=1, `stallreq_ex`=0) in cycle N+33; EX retires at the end of N+33 if `ex_hold`=0.
- Total latency is 34 cycles including the DONE cycle.
- `rst` mid-operation wins over everything: IDLE next cycle.
- `annul` and `start` in the same IDLE cycle: no capture, `stallreq_ex`=0.
- `ex_hold`=1 in DONE: `result` stays stable for any number of cycles.

## Configuration
- `DIV_FAST_SPECIAL_EN` defined:
  - In IDLE, a zero divisor or signed 0x80000000/-1 skips BUSY and goes directly to DONE.
  - The result is the architectural value and is ready in cycle N+1.
  - `stallreq_ex` is high only in cycle N.
- Not defined: every operation takes the full 32 steps, with identical results.

## Structure
- Shared defines package holds `XLEN`, the `DIV_OP_*` encodings and the FSM state encodings (`DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`).
- One sub-module, `div_step`: combinational single restoring step (rem33/q in → rem/q out).
- FSM, counter, sign handling and output registers stay in `div_unit`.

## Test plan
- DIVU 100/7, `ex_hold`=0 → `stallreq_ex` high 33 cycles; `ready` in cycle N+33 with `result`=14. Repeat as REMU → 2.
- DIV -7/2 → -3 (0xFFFFFFFD); REM -7/2 → -1; REM 7/-2 → 1.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/-1 → 0x80000000, REM → 0. With `DIV_FAST_SPECIAL_EN`, `ready` in cycle N+1.
- `annul` at BUSY step 10 → IDLE next cycle, `ready` never asserts, `stallreq_ex` drops the same cycle; a following DIVU 9/3 → 3.
- `ex_hold`=1 for 5 cycles in DONE → `ready`=1 and `result` stable throughout, no restart; IDLE one cycle after `ex_hold` falls.
- `rst` asserted at BUSY step 20 → next cycle all outputs 0 and state IDLE.
